// File: rtl/hamming_search_ctrl.sv
// Nearest-pattern search: scans DEPTH stored N-bit patterns with one XOR/popcount
// stage and reports the lowest-index pattern at minimum Hamming distance.
// Optional macro HAMMING_EARLY_EXIT_EN: finish as soon as an exact match is compared.
module hamming_search_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned DW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          start,
  input  logic [N-1:0]  query,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] best_idx,
  output logic [DW-1:0] best_dist
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic [N-1:0]  query_q, query_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] didx_q, didx_d;
  logic [DW-1:0] dist_q, dist_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] best_idx_q, best_idx_d;
  logic [DW-1:0] best_dist_q, best_dist_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [DW-1:0] popcount(input logic [N-1:0] v);
    logic [DW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) c = c + DW'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      query_q     <= '0;
      idx_q       <= '0;
      didx_q      <= '0;
      dist_q      <= '0;
      vld_q       <= 1'b0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      query_q     <= query_d;
      idx_q       <= idx_d;
      didx_q      <= didx_d;
      dist_q      <= dist_d;
      vld_q       <= vld_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    query_d     = query_q;
    idx_d       = idx_q;
    didx_d      = didx_q;
    dist_d      = dist_q;
    vld_d       = 1'b0;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (wr_en && !busy_q) mem_d[wr_addr] = wr_data;

    // Strict less-than keeps the earliest index on ties
    if (vld_q && (dist_q < best_dist_q)) begin
      best_dist_d = dist_q;
      best_idx_d  = didx_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          query_d     = query;
          idx_d       = '0;
          best_dist_d = DW'(N);
          best_idx_d  = '0;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        dist_d = popcount(query_q ^ mem_q[idx_q]);
        didx_d = idx_q;
        vld_d  = 1'b1;
        idx_d  = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

`ifdef HAMMING_EARLY_EXIT_EN
    // An exact match cannot be beaten; drop whatever distance is in flight
    if (vld_q && (dist_q == '0)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      vld_d   = 1'b0;
    end
`else
`endif
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign best_idx  = best_idx_q;
  assign best_dist = best_dist_q;

endmodule
